// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// One operation is in flight at a time. Its result and flags are captured and held until the consumer takes them.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_cin,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_cin,
  output logic              alu_en,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_c,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_res,
  output logic              rsp_cout,
  output logic              rsp_z,
  output logic              rsp_n,
  output logic              rsp_err,
  output logic              busy,
  output logic [15:0]       ops_done
);

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(6'b010000);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(6'b010001);
  localparam logic [OP_W-1:0] OP_EQ  = OP_W'(6'b100000);
  localparam logic [OP_W-1:0] OP_NE  = OP_W'(6'b100001);
  localparam logic [OP_W-1:0] OP_LE  = OP_W'(6'b100010);
  localparam logic [OP_W-1:0] OP_GT  = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_LLS = OP_W'(6'b110000);
  localparam logic [OP_W-1:0] OP_LRS = OP_W'(6'b110001);
  localparam logic [OP_W-1:0] OP_ARS = OP_W'(6'b110010);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_EQ, OP_NE, OP_LE, OP_GT, OP_LLS, OP_LRS, OP_ARS: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_id;
  logic [OP_W-1:0]     r_alu_op;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic                r_alu_c;
  logic                r_rsp_id;
  logic [DATA_W-1:0]   r_rsp_res;
  logic                r_rsp_cout;
  logic                r_rsp_z;
  logic                r_rsp_n;
  logic                r_rsp_err;
  logic [15:0]         r_ops_done;

  logic                w_hs;
  logic                w_rsp_accept;
  logic                w_sel_id;
  logic [OP_W-1:0]     w_sel_op;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;
  logic                w_sel_cin;
  logic                w_sel_legal;
  logic                w_is_arith;

  // The grant goes to req1 exactly when req1_ready is high, so the payload mux keys off that signal.
  assign w_sel_id    = req1_ready;
  assign w_sel_op    = w_sel_id ? req1_op  : req0_op;
  assign w_sel_a     = w_sel_id ? req1_a   : req0_a;
  assign w_sel_b     = w_sel_id ? req1_b   : req0_b;
  assign w_sel_cin   = w_sel_id ? req1_cin : req0_cin;
  assign w_sel_legal = is_legal(w_sel_op);
  assign w_is_arith  = (r_alu_op == OP_ADD) || (r_alu_op == OP_SUB);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    w_hs         = 1'b0;
    w_rsp_accept = 1'b0;
    alu_en       = 1'b0;
    rsp_valid    = 1'b0;
    busy         = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        busy       = 1'b0;
        // r_last_id names the last grant, so on a tie the other requester wins.
        req0_ready = req0_valid && (!req1_valid || r_last_id);
        req1_ready = req1_valid && (!req0_valid || !r_last_id);
        w_hs       = req0_ready || req1_ready;
        if (w_hs) w_state_nxt = w_sel_legal ? S_EXEC : S_RESP;
      end
      S_EXEC: begin
        alu_en      = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_rsp_accept = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: every datapath register is reset, because each one drives a port whose reset value is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_id  <= 1'b1;
      r_alu_op   <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_c    <= 1'b0;
      r_rsp_id   <= 1'b0;
      r_rsp_res  <= '0;
      r_rsp_cout <= 1'b0;
      r_rsp_z    <= 1'b0;
      r_rsp_n    <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_ops_done <= '0;
    end else begin
      if (w_hs) begin
        r_last_id <= w_sel_id;
        r_alu_op  <= w_sel_op;
        r_alu_a   <= w_sel_a;
        r_alu_b   <= w_sel_b;
        r_alu_c   <= w_sel_cin;
        r_rsp_id  <= w_sel_id;
        if (!w_sel_legal) begin
          r_rsp_res  <= '0;
          r_rsp_cout <= 1'b0;
          r_rsp_z    <= 1'b0;
          r_rsp_n    <= 1'b0;
          r_rsp_err  <= 1'b1;
        end
      end
      if (r_state == S_EXEC) begin
        r_rsp_res  <= alu_res;
        r_rsp_cout <= w_is_arith ? alu_cout : 1'b0;
        r_rsp_z    <= (alu_res == '0);
        r_rsp_n    <= alu_res[DATA_W-1];
        r_rsp_err  <= 1'b0;
      end
      if (w_rsp_accept) r_ops_done <= r_ops_done + 16'd1;
    end
  end

  assign alu_op   = r_alu_op;
  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_c    = r_alu_c;
  assign rsp_id   = r_rsp_id;
  assign rsp_res  = r_rsp_res;
  assign rsp_cout = r_rsp_cout;
  assign rsp_z    = r_rsp_z;
  assign rsp_n    = r_rsp_n;
  assign rsp_err  = r_rsp_err;
  assign ops_done = r_ops_done;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, multi-cycle corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int OW = 6;

  localparam logic [5:0] OP_ADD = 6'b010000;
  localparam logic [5:0] OP_SUB = 6'b010001;
  localparam logic [5:0] OP_EQ  = 6'b100000;
  localparam logic [5:0] OP_NE  = 6'b100001;
  localparam logic [5:0] OP_LE  = 6'b100010;
  localparam logic [5:0] OP_GT  = 6'b100011;
  localparam logic [5:0] OP_LLS = 6'b110000;
  localparam logic [5:0] OP_LRS = 6'b110001;
  localparam logic [5:0] OP_ARS = 6'b110010;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req0_cin;
  logic [OW-1:0] req0_op;
  logic [DW-1:0] req0_a, req0_b;
  logic          req1_valid, req1_ready, req1_cin;
  logic [OW-1:0] req1_op;
  logic [DW-1:0] req1_a, req1_b;
  logic          alu_en, alu_c, alu_cout;
  logic [OW-1:0] alu_op;
  logic [DW-1:0] alu_a, alu_b, alu_res;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_z, rsp_n, rsp_err, busy;
  logic [DW-1:0] rsp_res;
  logic [15:0]   ops_done;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .alu_res(alu_res), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_res(rsp_res),
    .rsp_cout(rsp_cout), .rsp_z(rsp_z), .rsp_n(rsp_n), .rsp_err(rsp_err),
    .busy(busy), .ops_done(ops_done)
  );

  // Shared ALU model. For non-arithmetic ops its carry is deliberately junk, which the controller must mask.
  always_comb begin
    alu_res  = '0;
    alu_cout = ^alu_a;
    case (alu_op)
      OP_ADD: {alu_cout, alu_res} = {1'b0, alu_a} + {1'b0, alu_b} + 33'(alu_c);
      OP_SUB: {alu_cout, alu_res} = {1'b0, alu_a} - {1'b0, alu_b} - 33'(alu_c);
      OP_EQ:  alu_res = 32'(alu_a == alu_b);
      OP_NE:  alu_res = 32'(alu_a != alu_b);
      OP_LE:  alu_res = 32'(alu_a <= alu_b);
      OP_GT:  alu_res = 32'(alu_a > alu_b);
      OP_LLS: alu_res = alu_a << alu_b[4:0];
      OP_LRS: alu_res = alu_a >> alu_b[4:0];
      OP_ARS: alu_res = $signed(alu_a) >>> alu_b[4:0];
      default: ;
    endcase
  end

  typedef struct packed {
    logic [31:0] res;
    logic        cout;
    logic        z;
    logic        n;
    logic        err;
  } rsp_t;

  typedef struct {
    logic        id;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] res;
    logic        cout;
    logic        z;
    logic        n;
    logic        err;
    int          hold;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s: bounded wait expired (t=%0t)", name, $time);
  endtask

  // The expected response is computed with plain integer arithmetic, following the opcode definitions.
  function automatic rsp_t ref_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin);
    rsp_t   r;
    longint s, sa, sh;
    int     k;
    r  = '0;
    s  = 0;
    k  = int'(b % 32);
    sh = longint'(1) << k;
    case (op)
      OP_ADD: begin
        s = longint'(a) + longint'(b) + longint'(cin);
        r.cout = (s >= 64'sh1_0000_0000);
      end
      OP_SUB: begin
        s = longint'(a) - longint'(b) - longint'(cin);
        r.cout = (s < 0);
      end
      OP_EQ:  s = (a == b) ? 1 : 0;
      OP_NE:  s = (a != b) ? 1 : 0;
      OP_LE:  s = (a <= b) ? 1 : 0;
      OP_GT:  s = (a > b) ? 1 : 0;
      OP_LLS: s = longint'(a) * sh;
      OP_LRS: s = longint'(a) / sh;
      OP_ARS: begin
        sa = longint'($signed(a));
        s  = (sa >= 0) ? sa / sh : -((-sa + sh - 1) / sh);
      end
      default: r.err = 1'b1;
    endcase
    if (!r.err) begin
      r.res = s[31:0];
      r.z   = (r.res == 32'h0);
      r.n   = r.res[31];
    end
    return r;
  endfunction

  task automatic set_req(input logic id, input logic v, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic cin);
    if (id) begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_cin = cin;
    end else begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_cin = cin;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [15:0] exp_ops;

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    bit ok, got_en;
    @(negedge clk);
    set_req(v.id, 1'b1, v.op, v.a, v.b, v.cin);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (v.id ? req1_ready : req0_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin fail_now({tag, "_grant"}); return; end
    @(posedge clk);
    #1 set_req(v.id, 1'b0, v.op, v.a, v.b, v.cin);
    lat = 0; got_en = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (alu_en) begin
        got_en = 1;
        check({tag, "_alu_opab"}, {alu_op, alu_a, alu_b, alu_c}, {v.op, v.a, v.b, v.cin});
      end
      if (rsp_valid) break;
    end
    check({tag, "_latency"}, lat, v.err ? 1 : 2);
    check({tag, "_alu_en_seen"}, got_en, !v.err);
    for (int h = 0; h < v.hold; h++) begin
      if (h > 0) @(negedge clk);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      check({tag, "_rsp_valid"}, rsp_valid, 1);
      check({tag, "_ready_in_resp"}, {req0_ready, req1_ready}, 2'b00);
      check({tag, "_id"}, rsp_id, v.id);
      check({tag, "_res"}, rsp_res, v.res);
      check({tag, "_flags"}, {rsp_cout, rsp_z, rsp_n, rsp_err}, {v.cout, v.z, v.n, v.err});
      check({tag, "_ops_hold"}, ops_done, exp_ops);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    exp_ops++;
    @(negedge clk);
    check({tag, "_ops_done"}, ops_done, exp_ops);
    check({tag, "_idle_after"}, {rsp_valid, busy}, 2'b00);
  endtask

  vec_t vecs[14];

  logic [5:0] legal_ops[9] = '{OP_ADD, OP_SUB, OP_EQ, OP_NE, OP_LE, OP_GT, OP_LLS, OP_LRS, OP_ARS};

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   gid[8];
    int   gcyc[8];
    int   ng;
    bit   pend[2];
    bit   hs_prev[2];
    logic [5:0]  p_op[2];
    logic [31:0] p_a[2], p_b[2];
    logic        p_cin[2];
    bit   m_busy, m_last, m_id, e0, e1, ok;
    int   m_delay;
    rsp_t m_exp;
    logic [15:0] m_ops;

    vecs[0]  = '{1'b0, OP_ADD,    32'hFFFFFFFF, 32'h1, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    vecs[1]  = '{1'b1, OP_SUB,    32'h5,        32'h7, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b1, 1'b0, 5};
    vecs[2]  = '{1'b1, 6'b000000, 32'h1234,     32'h5, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[3]  = '{1'b0, OP_ADD,    32'd10,       32'd20, 1'b1, 32'h0000001F, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[4]  = '{1'b0, OP_SUB,    32'h0,        32'h0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 2};
    vecs[5]  = '{1'b1, OP_EQ,     32'h7,        32'h7, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[6]  = '{1'b0, OP_NE,     32'h1,        32'h1, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[7]  = '{1'b1, OP_LE,     32'h7,        32'h9, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{1'b0, OP_GT,     32'h7,        32'h9, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[9]  = '{1'b1, OP_LLS,    32'h1,        32'd31, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[10] = '{1'b0, OP_LRS,    32'h80000000, 32'd4, 1'b0, 32'h08000000, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[11] = '{1'b1, OP_ARS,    32'h80000000, 32'd4, 1'b0, 32'hF8000000, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[12] = '{1'b0, 6'b010010, 32'h1,        32'h1, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[13] = '{1'b1, 6'b111111, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 2};

    rst = 1'b1;
    rsp_ready = 1'b0;
    set_req(1'b0, 1'b0, '0, '0, '0, 1'b0);
    set_req(1'b1, 1'b0, '0, '0, '0, 1'b0);
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_ctrl", {busy, rsp_valid, alu_en, req0_ready, req1_ready}, 5'b0);
    check("rst_alu", {alu_op, alu_a, alu_b, alu_c}, '0);
    check("rst_rsp", {rsp_id, rsp_res, rsp_cout, rsp_z, rsp_n, rsp_err}, '0);
    check("rst_ops", ops_done, 16'h0);

    // Both requesters valid throughout: grants alternate from req0, one every 3 cycles
    rsp_ready = 1'b1;
    set_req(1'b0, 1'b1, OP_ADD, 32'h1, 32'h2, 1'b0);
    set_req(1'b1, 1'b1, OP_SUB, 32'h9, 32'h3, 1'b0);
    ng = 0;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if ((req0_ready || req1_ready) && ng < 8) begin
        gid[ng]  = req1_ready ? 1 : 0;
        gcyc[ng] = c;
        ng++;
      end
    end
    if (ng < 4) fail_now("rr_grant_count");
    else begin
      for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d_id", i), gid[i], i % 2);
      for (int i = 0; i < 3; i++) check($sformatf("rr_gap%0d", i), gcyc[i+1] - gcyc[i], 3);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) fail_now("rr_drain");
    rsp_ready = 1'b0;

    // Directed vector table
    do_reset();
    exp_ops = 16'h0;
    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset during EXEC discards the operation and restores the req0-first tie-break
    @(negedge clk);
    set_req(1'b1, 1'b1, OP_ADD, 32'h3, 32'h4, 1'b0);
    #1;
    check("rstx_grant1", req1_ready, 1);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    @(negedge clk);
    check("rstx_in_exec", alu_en, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstx_state", {busy, rsp_valid, alu_en}, 3'b000);
    check("rstx_ops", ops_done, 16'h0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("rstx_tie", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    rsp_ready = 1'b0;

    // Randomized traffic against the reference model
    do_reset();
    m_busy = 0; m_last = 1; m_delay = 0; m_ops = 16'h0; m_id = 0; m_exp = '0;
    pend = '{0, 0}; hs_prev = '{0, 0};
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (hs_prev[r]) pend[r] = 0;
        if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r]  = 1;
          p_op[r]  = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, 8)] : 6'($urandom);
          p_a[r]   = rand_word();
          p_b[r]   = rand_word();
          p_cin[r] = 1'($urandom);
        end
        set_req(1'(r), pend[r], p_op[r], p_a[r], p_b[r], p_cin[r]);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      e0 = !m_busy && pend[0] && (!pend[1] || m_last);
      e1 = !m_busy && pend[1] && (!pend[0] || !m_last);
      check("rnd_ready", {req0_ready, req1_ready}, {e0, e1});
      check("rnd_busy", busy, m_busy);
      check("rnd_alu_en", alu_en, m_busy && m_delay > 0);
      check("rnd_rsp_valid", rsp_valid, m_busy && m_delay == 0);
      check("rnd_ops", ops_done, m_ops);
      if (m_busy && m_delay == 0) begin
        check("rnd_rsp_id", rsp_id, m_id);
        check("rnd_rsp_res", rsp_res, m_exp.res);
        check("rnd_rsp_flags", {rsp_cout, rsp_z, rsp_n, rsp_err}, {m_exp.cout, m_exp.z, m_exp.n, m_exp.err});
      end
      hs_prev[0] = e0;
      hs_prev[1] = e1;
      if (m_busy) begin
        if (m_delay > 0) m_delay--;
        else if (rsp_ready) begin
          m_busy = 0;
          m_ops++;
        end
      end else if (e0 || e1) begin
        m_id    = e1;
        m_exp   = ref_op(p_op[m_id], p_a[m_id], p_b[m_id], p_cin[m_id]);
        m_busy  = 1;
        m_delay = m_exp.err ? 0 : 1;
        m_last  = m_id;
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
